// File: rtl/lock_pkg.sv
// Shared types and key defaults for the lockable-register write path.
package lock_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA = 2'd0,
        ADDR_LOCK = 2'd1,
        ADDR_KEY  = 2'd2,
        ADDR_RSVD = 2'd3
    } addr_e;

    typedef enum logic [1:0] {
        K_IDLE = 2'd0,
        K_HALF = 2'd1,
        K_OPEN = 2'd2
    } key_state_e;

    localparam logic [15:0] KEY_A_DEF = 16'hA5A5;
    localparam logic [15:0] KEY_B_DEF = 16'h5A5A;

endpackage

// File: rtl/dbg_unlock_fsm.sv
// Two-key debug unlock sequencer with a bounded open window.
module dbg_unlock_fsm
    import lock_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] KEY_A      = KEY_A_DEF,
    parameter logic [DATA_W-1:0] KEY_B      = KEY_B_DEF,
    parameter int                DBG_CYCLES = 256
) (
    input  logic              Clk,
    input  logic              resetn,
    input  logic              key_strobe,
    input  logic [DATA_W-1:0] key_value,
    input  logic              scan_mode,
    output logic              key_err,
    output logic              debug_unlocked
);

    localparam int CNT_W = (DBG_CYCLES > 2) ? $clog2(DBG_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD = CNT_W'(DBG_CYCLES - 1);

    key_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic             rekey;
    logic             is_a;
    logic             is_b;

    assign is_a = (key_value == KEY_A);
    assign is_b = (key_value == KEY_B);

    always_comb begin
        key_err = 1'b0;
        if (key_strobe && !scan_mode) begin
            unique case (state)
                K_IDLE:  key_err = !is_a;
                K_HALF:  key_err = !is_b;
                default: key_err = 1'b0;
            endcase
        end
    end

    // rekey remembers a KEY_A seen inside the window so KEY_B can reload it
    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            state <= K_IDLE;
            cnt   <= '0;
            rekey <= 1'b0;
        end else if (scan_mode) begin
            state <= K_IDLE;
            rekey <= 1'b0;
        end else begin
            unique case (state)
                K_IDLE: begin
                    if (key_strobe && is_a)
                        state <= K_HALF;
                end
                K_HALF: begin
                    if (key_strobe) begin
                        if (is_b) begin
                            state <= K_OPEN;
                            cnt   <= LOAD;
                            rekey <= 1'b0;
                        end else begin
                            state <= K_IDLE;
                        end
                    end
                end
                K_OPEN: begin
                    if (key_strobe && is_b && rekey) begin
                        cnt   <= LOAD;
                        rekey <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= K_IDLE;
                        rekey <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (key_strobe)
                            rekey <= is_a;
                    end
                end
                default: state <= K_IDLE;
            endcase
        end
    end

    assign debug_unlocked = (state == K_OPEN);

endmodule

// File: rtl/lock_write_ctrl.sv
// Request decoder driving the lockable register's data/write/lock strobes.
module lock_write_ctrl
    import lock_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] KEY_A      = KEY_A_DEF,
    parameter logic [DATA_W-1:0] KEY_B      = KEY_B_DEF,
    parameter int                DBG_CYCLES = 256,
    parameter int                ERR_W      = 8
) (
    input  logic              Clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              scan_mode,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] reg_data,
    output logic              reg_write,
    output logic              reg_lock,
    output logic              debug_unlocked,
    output logic              locked,
    output logic [ERR_W-1:0]  err_count
);

    logic  accept;
    logic  key_strobe;
    logic  key_err;
    logic  do_write;
    logic  do_lock;
    logic  reject;
    addr_e addr;

    assign req_ready  = !resp_valid;
    assign accept     = req_valid && req_ready;
    assign addr       = addr_e'(req_addr);
    assign key_strobe = accept && (addr == ADDR_KEY);

    dbg_unlock_fsm #(
        .DATA_W     (DATA_W),
        .KEY_A      (KEY_A),
        .KEY_B      (KEY_B),
        .DBG_CYCLES (DBG_CYCLES)
    ) u_dbg (
        .Clk            (Clk),
        .resetn         (resetn),
        .key_strobe     (key_strobe),
        .key_value      (req_wdata),
        .scan_mode      (scan_mode),
        .key_err        (key_err),
        .debug_unlocked (debug_unlocked)
    );

    always_comb begin
        do_write = 1'b0;
        do_lock  = 1'b0;
        reject   = 1'b0;
        unique case (addr)
            ADDR_DATA: begin
                do_write = !scan_mode && (!locked || debug_unlocked);
                reject   = !do_write;
            end
            ADDR_LOCK: begin
                do_lock = !scan_mode && req_wdata[0];
                reject  = scan_mode;
            end
            ADDR_KEY:  reject = scan_mode || key_err;
            ADDR_RSVD: reject = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge resetn) begin
        if (!resetn) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            reg_write  <= 1'b0;
            reg_lock   <= 1'b0;
            reg_data   <= '0;
            locked     <= 1'b0;
            err_count  <= '0;
        end else begin
            resp_valid <= accept;
            resp_err   <= accept && reject;
            reg_write  <= accept && do_write;
            reg_lock   <= accept && do_lock;
            if (accept && do_write)
                reg_data <= req_wdata;
            if (accept && do_lock)
                locked <= 1'b1;
            // counts alongside the response so both are visible together
            if (accept && reject && !(&err_count))
                err_count <= err_count + 1'b1;
        end
    end

endmodule
